// File: rtl/park_occupancy_ctrl.sv
// Parking-lot occupancy controller: debounced entry/exit sensor FSMs feeding a saturating free-slot counter.
// Define PARK_STATS_EN to add the total_in/total_out lifetime counters.
module park_occupancy_ctrl #(
  parameter int N_GATE   = 2,
  parameter int DIST_W   = 13,
  parameter int THRESH   = 60,
  parameter int DEB      = 3,
  parameter int CAPACITY = 10,
  parameter int TICK_MAX = 4_999_999
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [N_GATE*DIST_W-1:0] dist_in,
  input  logic [N_GATE*DIST_W-1:0] dist_out,
  output logic                     tick_flag,
  output logic [N_GATE-1:0]        entry_evt,
  output logic [N_GATE-1:0]        exit_evt,
  output logic [N_GATE-1:0]        entry_deny,
  output logic [7:0]               free_slots,
  output logic                     full,
  output logic                     empty
`ifdef PARK_STATS_EN
  ,
  output logic [15:0]              total_in,
  output logic [15:0]              total_out
`endif
);

  localparam int                NCH    = 2 * N_GATE;
  localparam int                TW     = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam logic [TW-1:0]     TICK_L = TW'(TICK_MAX);
  localparam logic [DIST_W-1:0] THR    = DIST_W'(THRESH);
  localparam logic [4:0]        DEB_L  = 5'(DEB);
  localparam logic [7:0]        CAP    = 8'(CAPACITY);

  typedef enum logic [1:0] {CLEAR, ARRIVING, PRESENT, LEAVING} chan_state_t;

  logic [TW-1:0]  tick_cnt;
  logic [NCH-1:0] near;
  chan_state_t    state [NCH];
  chan_state_t    state_nxt [NCH];
  logic [3:0]     deb_cnt [NCH];
  logic [3:0]     deb_cnt_nxt [NCH];
  logic [NCH-1:0] pass_nxt;
  logic [NCH-1:0] pass_p0;
  logic [7:0]     slots;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= CAP) ? CAP : v + 8'd1;
  endfunction

  function automatic logic [4:0] inc_cnt(input logic [3:0] v);
    return {1'b0, v} + 5'd1;
  endfunction

  // Stage 0: sample tick generation
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tick_cnt  <= '0;
      tick_flag <= 1'b0;
    end else begin
      tick_flag <= (tick_cnt == TICK_L);
      tick_cnt  <= (tick_cnt == TICK_L) ? '0 : tick_cnt + TW'(1);
    end
  end

  always_comb begin
    near = '0;
    for (int g = 0; g < N_GATE; g++) begin
      near[g]          = dist_in[g*DIST_W +: DIST_W] < THR;
      near[N_GATE + g] = dist_out[g*DIST_W +: DIST_W] < THR;
    end
  end

  // Stage 1: per-channel presence FSMs; a completed LEAVING->CLEAR becomes a pass
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int c = 0; c < NCH; c++) begin
        state[c]   <= CLEAR;
        deb_cnt[c] <= '0;
      end
      pass_p0 <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        state[c]   <= state_nxt[c];
        deb_cnt[c] <= deb_cnt_nxt[c];
      end
      pass_p0 <= pass_nxt;
    end
  end

  always_comb begin
    pass_nxt = '0;
    for (int c = 0; c < NCH; c++) begin
      state_nxt[c]   = state[c];
      deb_cnt_nxt[c] = deb_cnt[c];
      if (tick_flag) begin
        // The sample that leaves a stable state counts as the first agreeing one.
        case (state[c])
          CLEAR: begin
            if (near[c]) begin
              state_nxt[c]   = ARRIVING;
              deb_cnt_nxt[c] = 4'd1;
            end
          end
          ARRIVING: begin
            if (!near[c])                         state_nxt[c]   = CLEAR;
            else if (inc_cnt(deb_cnt[c]) >= DEB_L) state_nxt[c]   = PRESENT;
            else                                  deb_cnt_nxt[c] = deb_cnt[c] + 4'd1;
          end
          PRESENT: begin
            if (!near[c]) begin
              state_nxt[c]   = LEAVING;
              deb_cnt_nxt[c] = 4'd1;
            end
          end
          LEAVING: begin
            if (near[c]) begin
              state_nxt[c] = PRESENT;
            end else if (inc_cnt(deb_cnt[c]) >= DEB_L) begin
              state_nxt[c] = CLEAR;
              pass_nxt[c]  = 1'b1;
            end else begin
              deb_cnt_nxt[c] = deb_cnt[c] + 4'd1;
            end
          end
          default: state_nxt[c] = CLEAR;
        endcase
      end
    end
  end

  // Stage 2: resolve passes against the slot count (exits first, then entries by index)
  always_comb begin
    slots      = free_slots;
    exit_evt   = '0;
    entry_evt  = '0;
    entry_deny = '0;
    for (int g = 0; g < N_GATE; g++) begin
      if (pass_p0[N_GATE + g]) begin
        exit_evt[g] = 1'b1;
        slots       = sat_inc(slots);
      end
    end
    for (int g = 0; g < N_GATE; g++) begin
      if (pass_p0[g]) begin
        if (slots != 8'd0) begin
          entry_evt[g] = 1'b1;
          slots        = slots - 8'd1;
        end else begin
          entry_deny[g] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) free_slots <= CAP;
    else         free_slots <= slots;
  end

  assign full  = (free_slots == 8'd0);
  assign empty = (free_slots == CAP);

`ifdef PARK_STATS_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      total_in  <= '0;
      total_out <= '0;
    end else begin
      total_in  <= total_in + 16'($countones(entry_evt));
      total_out <= total_out + 16'($countones(exit_evt));
    end
  end
`endif

endmodule

// File: doc/park_occupancy_ctrl.md
PARK_OCCUPANCY_CTRL -- requirements
Module: park_occupancy_ctrl

Interface
REQ-001 SHALL have parameter N_GATE, default 2: number of entry sensors and number of exit sensors (1..8).
REQ-002 SHALL have parameter DIST_W, default 13: width of each distance sample.
REQ-003 SHALL have parameter THRESH, default 60: a vehicle is present when distance < THRESH.
REQ-004 SHALL have parameter DEB, default 3: consecutive agreeing ticks required to change presence state (1..15).
REQ-005 SHALL have parameter CAPACITY, default 10: total number of slots (1..255).
REQ-006 SHALL have parameter TICK_MAX, default 4_999_999: sample tick period minus 1, in clocks.
REQ-007 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port sys_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 SHALL have port dist_in, input, N_GATE*DIST_W bits: entry-sensor distances; channel k is bits [k*DIST_W +: DIST_W].
REQ-010 SHALL have port dist_out, input, N_GATE*DIST_W bits: exit-sensor distances, packed the same way as dist_in.
REQ-011 SHALL have port tick_flag, output, 1 bit: one-cycle pulse at each sample tick.
REQ-012 SHALL have port entry_evt, output, N_GATE bits: per-channel one-cycle pulse for an accepted vehicle entry.
REQ-013 SHALL have port exit_evt, output, N_GATE bits: per-channel one-cycle pulse for a vehicle exit.
REQ-014 SHALL have port entry_deny, output, N_GATE bits: per-channel one-cycle pulse for an entry refused because the lot is full.
REQ-015 SHALL have port free_slots, output, 8 bits: number of free slots.
REQ-016 SHALL have ports full and empty, outputs, 1 bit each: full = (free_slots == 0); empty = (free_slots == CAPACITY).

Function
REQ-017 SHALL run a tick counter 0..TICK_MAX that wraps to 0; tick_flag SHALL be 1 for exactly the one cycle after the counter equals TICK_MAX.
REQ-018 SHALL sample every sensor, on each tick_flag cycle only, as near = (dist < THRESH); the compare is unsigned at DIST_W bits.
REQ-019 SHALL give each of the 2*N_GATE channels its own FSM with states CLEAR, ARRIVING, PRESENT and LEAVING.
REQ-020 SHALL advance each FSM as follows: CLEAR goes to ARRIVING on a near sample; ARRIVING goes to PRESENT after DEB consecutive near samples; ARRIVING returns to CLEAR on any far sample; PRESENT goes to LEAVING on a far sample; LEAVING goes to CLEAR after DEB consecutive far samples; LEAVING returns to PRESENT on any near sample.
REQ-021 SHALL register a pass on the transition LEAVING to CLEAR; the event pulse SHALL appear in the cycle after that tick_flag cycle.
REQ-022 SHALL register a pass only after the full PRESENT-then-LEAVING sequence; a near pulse shorter than DEB ticks SHALL generate no event.
REQ-023 SHALL, in the cycle an event pulse is asserted, apply all exit passes first, then entry passes in ascending channel index.
REQ-024 SHALL accept an entry pass (entry_evt) only while a free slot remains after the passes applied before it; otherwise the pass SHALL raise entry_deny and leave free_slots unchanged.
REQ-025 SHALL update free_slots one cycle after the event pulses; the new value = old + exits - accepted entries.
REQ-026 SHALL saturate free_slots at CAPACITY; an exit seen while empty SHALL be dropped silently.
REQ-027 SHALL never let free_slots wrap below 0 or exceed CAPACITY.
REQ-028 SHALL derive full and empty combinationally from free_slots.

Reset
REQ-029 SHALL, while sys_rst = 1, asynchronously set free_slots = CAPACITY, all FSMs = CLEAR, the tick counter = 0, and every pulse output = 0.
REQ-030 SHALL, when reset is asserted mid-debounce or mid-pass, discard the pending pass with no event after release.

Configuration
REQ-031 SHALL, when PARK_STATS_EN is defined, add outputs total_in[15:0] and total_out[15:0]; each counts accepted entries and exits respectively, wraps at 65535 to 0, and resets to 0.
REQ-032 SHALL, when PARK_STATS_EN is not defined, omit those ports and counters entirely; all other behaviour is unchanged.

Verification
REQ-033 SHALL cover single entry: TICK_MAX=3, DEB=3; entry ch0 at 40 for 4 ticks, then 100 for 3 ticks -> one entry_evt[0] pulse, free_slots 10 -> 9 one cycle later.
REQ-034 SHALL cover glitch rejection: entry ch0 at 40 for 2 ticks, then 100 -> no entry_evt, free_slots stays 10.
REQ-035 SHALL cover full lot: CAPACITY=2, three sequential entries -> entry_evt, entry_evt, then entry_deny; free_slots 2 -> 1 -> 0; full = 1.
REQ-036 SHALL cover simultaneous events: free_slots = 0; exit ch1 and entries ch0 and ch1 complete on the same tick -> exit_evt[1], entry_evt[0] and entry_deny[1]; free_slots stays 0.
REQ-037 SHALL cover empty exit and reset: an exit while empty -> free_slots stays at CAPACITY; sys_rst pulsed mid-LEAVING -> no event after release, free_slots = CAPACITY.
REQ-038 SHALL cover statistics: with PARK_STATS_EN defined, 3 entries and 1 exit -> total_in = 3, total_out = 1.
